// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: drives a 4:1 mux channel by channel and reassembles its output for self-check.
// Ports:
//   clk_in, rst_n_in          clock, async active-low reset
//   start_in, word_in         scan request (IDLE only) and word latched on accept
//   data_out, sel_out         registered mux data_in / sel_in drive
//   y_in                      mux y_out return, sampled on the last dwell cycle of each channel
//   busy_out, done_out        scan in progress / one-cycle completion pulse
//   capture_out, match_out    reassembled word and its comparison against data_out
//   mismatch_cnt_out          saturating count of mismatched scans
module mux_scan_ctrl #(
  parameter int DWELL = 1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       start_in,
  input  logic [3:0] word_in,
  output logic [3:0] data_out,
  output logic [1:0] sel_out,
  input  logic       y_in,
  output logic       busy_out,
  output logic [3:0] capture_out,
  output logic       done_out,
  output logic       match_out,
  output logic [7:0] mismatch_cnt_out
);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  localparam logic [3:0] LAST = 4'(DWELL - 1);
  state_t state_q, state_d;
  logic [3:0] data_q, data_d, cap_q, cap_d, dwell_q, dwell_d, shadow_q, shadow_d;
  logic [1:0] sel_q, sel_d;
  logic       match_q, match_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last, fin;
  assign last = state_q == DRIVE && dwell_q == LAST;
  assign fin  = last && sel_q == 2'd3;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE  ? (start_in ? DRIVE : IDLE) :
              state_q == DRIVE ? (fin ? DONE : DRIVE) : IDLE;
  end
  // sel wraps 3->0 on the final sample, so it is already 0 when IDLE is reached
  always_comb begin
    data_d   = state_q == IDLE && start_in ? word_in : data_q;
    dwell_d  = state_q == DRIVE ? (last ? 4'd0 : dwell_q + 4'd1) : 4'd0;
    sel_d    = last ? sel_q + 2'd1 : sel_q;
    shadow_d = shadow_q;
    if (last) shadow_d[sel_q] = y_in;
    cap_d    = fin ? shadow_d : cap_q;
    match_d  = fin ? shadow_d == data_q : match_q;
    cnt_d    = fin && shadow_d != data_q && cnt_q != 8'hff ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_q   <= '0;
      sel_q    <= '0;
      dwell_q  <= '0;
      shadow_q <= '0;
      cap_q    <= '0;
      match_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      data_q   <= data_d;
      sel_q    <= sel_d;
      dwell_q  <= dwell_d;
      shadow_q <= shadow_d;
      cap_q    <= cap_d;
      match_q  <= match_d;
      cnt_q    <= cnt_d;
    end
  end
  always_comb begin
    busy_out         = state_q != IDLE;
    done_out         = state_q == DONE;
    data_out         = data_q;
    sel_out          = sel_q;
    capture_out      = cap_q;
    match_out        = match_q;
    mismatch_cnt_out = cnt_q;
  end
endmodule
